// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver, LSB first. The asynchronous rx line is brought into the
//   clk domain by a 2-flop synchronizer. Each start bit is re-checked at its
//   midpoint, and every later bit is sampled one bit period after the previous
//   sample. A good stop bit loads byte_out and pulses rx_done for one cycle.
//   A low stop bit pulses frame_err and discards the byte. The receiver then
//   waits until the line returns high before it looks for another start bit.
//
// Ports
//   clk        in   1  system clock; all logic runs on the rising edge
//   reset      in   1  asynchronous, active-high reset (asserts at once,
//                      releases synchronously)
//   rx         in   1  serial line, asynchronous to clk, idle high
//   byte_out   out  8  last correctly framed byte; held until the next good frame
//   rx_done    out  1  one-cycle pulse when byte_out is updated
//   frame_err  out  1  one-cycle pulse when the stop bit is sampled low
//   busy       out  1  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter  int CLKS_PER_BIT = 434,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    // Mid-start-bit point. Every later sample lands one full period after it.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       rst_pipe;
    logic             core_rst;
    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Reset stretcher: assertion reaches the core immediately, and release
    // is retimed to clk so that no flop sees reset drop near an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign core_rst = rst_pipe[1];

    // Synchronizer flops reset to 1 so the line reads as idle after reset.
    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here give a true two-stage
            // pipeline. Blocking ones would collapse it into a single flop.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            // NOTE: the shift register holds datapath only and does not need
            // a reset. Clearing it keeps simulation free of X values for a
            // single byte of storage.
            shift_reg <= 8'h00;
            byte_out  <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end

                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        // Line is high again at mid start bit: treat it as a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state   <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        // The FSM returns to IDLE at mid stop bit. This leaves
                        // half a bit period to catch a start bit that follows
                        // with no idle gap.
                        if (rx_s) begin
                            byte_out <= shift_reg;
                            rx_done  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // A break or stuck-low line must not be taken as a new start bit.
                    clk_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed and random frames for uart_rx_byte with CLKS_PER_BIT = 16.
//   The reference model is a queue of bytes expected in arrival order.
//   send_frame fills it for every frame that has a good stop bit. A negedge
//   monitor collects the bytes the DUT actually delivers and counts pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] byte_out;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_out (byte_out),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            check("pulse_exclusive", 128'(rx_done & frame_err), 128'd0);
            check("pulse_spacing", 128'(prev_pulse), 128'd0);
        end
        if (rx_done) begin
            done_cnt++;
            got_q.push_back(byte_out);
        end
        if (frame_err) err_cnt++;
        prev_pulse = rx_done | frame_err;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    // Holds the line idle until busy drops, within a bounded number of cycles.
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n  = 0;
        rx = 1'b1;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n >= budget), 128'd0);
        repeat (4) @(negedge clk);
    endtask

    // Compares the delivered bytes with the expected ones, then drains both queues.
    task automatic compare_sb(input string tag);
        check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, 128'(got_q.pop_front()), 128'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         d0, e0, gap;
        logic [7:0] rb;
        logic [127:0] exp_block, got_block;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({byte_out, rx_done, frame_err, busy}), 128'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // T1: a single good frame.
        send_frame(8'hA5, 1'b1);
        wait_idle("t1_timeout", 200);
        check("t1_done_cnt", 128'(done_cnt), 128'd1);
        check("t1_err_cnt", 128'(err_cnt), 128'd0);
        check("t1_byte_out", 128'(byte_out), 128'hA5);
        compare_sb("t1");

        // T2: three frames with no idle bits between them.
        d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_idle("t2_timeout", 200);
        check("t2_done_delta", 128'(done_cnt - d0), 128'd3);
        compare_sb("t2");

        // T3: a 4-cycle low glitch on the idle line.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_busy", 128'(busy), 128'd0);
        check("t3_no_pulse", 128'({done_cnt - d0, err_cnt - e0}), 128'd0);

        // T4: low stop bit, then the line stays low.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_busy_low", 128'(busy), 128'd1);
        check("t4_err_delta", 128'(err_cnt - e0), 128'd1);
        check("t4_no_done", 128'(done_cnt - d0), 128'd0);
        check("t4_byte_held", 128'(byte_out), 128'(last_good));
        wait_idle("t4_release_timeout", 20);
        check("t4_busy_released", 128'(busy), 128'd0);
        repeat (CPB) @(negedge clk);
        send_frame(8'h81, 1'b1);
        wait_idle("t4_timeout", 200);
        check("t4_byte_81", 128'(byte_out), 128'h81);
        compare_sb("t4");

        // T5: reset asserted in the middle of bit 4 of 0xC3.
        d0 = done_cnt;
        e0 = err_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb_c3(i));
        rx = rb_c3(4);
        repeat (CPB / 2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t5_async_reset", 128'({byte_out, rx_done, frame_err, busy}), 128'd0);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("t5_no_pulse", 128'({done_cnt - d0, err_cnt - e0}), 128'd0);
        check("t5_idle", 128'(busy), 128'd0);
        send_frame(8'h7E, 1'b1);
        wait_idle("t5_timeout", 200);
        check("t5_byte_7e", 128'(byte_out), 128'h7E);
        compare_sb("t5");

        // T6: 16 random bytes with random gaps, packed into a 128-bit block.
        // The first byte to arrive goes into the most significant byte.
        exp_block = '0;
        for (int k = 0; k < 16; k++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 2);
            exp_block = {exp_block[119:0], rb};
            send_frame(rb, 1'b1);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        wait_idle("t6_timeout", 200);
        got_block = '0;
        foreach (got_q[k]) got_block = {got_block[119:0], got_q[k]};
        check("t6_block", got_block, exp_block);
        compare_sb("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    function automatic logic rb_c3(input int i);
        logic [7:0] v;
        v = 8'hC3;
        return v[i];
    endfunction

endmodule
